// File: rtl/segdisp_pkg.sv
// Shared types and segment table for the 7-segment display controller.
// Segment patterns are g..a, active-low.
package segdisp_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [7:0] led8_t;

    localparam led8_t LED_OFF = 8'hFF;

    localparam seg7_t SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE,
        LATCH
    } state_t;

endpackage

// File: rtl/segdisp_if.sv
// Load handshake and display-data bundle between producer and
// the display controller.
interface segdisp_if #(
    parameter int DIGITS = 6
);

    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dots;
    logic [DIGITS-1:0]     blink_mask;
    logic                  blank_lz;

    modport master (
        output load_valid,
        output value,
        output dots,
        output blink_mask,
        output blank_lz,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  value,
        input  dots,
        input  blink_mask,
        input  blank_lz,
        output load_ready
    );

endinterface

// File: rtl/segdisp_hex_digit_enc.sv
// Combinational hex nibble to 7-segment (g..a, active-low) encoder.
module hex_digit_enc
    import segdisp_pkg::*;
(
    input  logic [3:0] nib,
    output seg7_t      seg
);

    assign seg = SEG_TAB[nib];

endmodule

// File: rtl/segdisp_ctrl.sv
// Multi-digit 7-segment controller with leading-zero blanking.
// Optional blink logic is built only with SEGDISP_BLINK_EN defined.
module segdisp_ctrl
    import segdisp_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset_n,
    segdisp_if.slave            bus,
    output logic [8*DIGITS-1:0] led
);

    state_t              st;
    logic                rdy;
    logic                acc;
    logic                have_q;
    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dots_q;
    logic [DIGITS-1:0]   mask_q;
    logic                blz_q;
    logic                phase;
    logic [DIGITS-1:0]   zhi;
    logic [8*DIGITS-1:0] led_d;
    seg7_t               seg [DIGITS];

    assign bus.load_ready = rdy;
    assign acc = bus.load_valid & rdy;

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        hex_digit_enc u_enc (
            .nib (val_q[4*g +: 4]),
            .seg (seg[g])
        );
    end

`ifdef SEGDISP_BLINK_EN
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          ph_q;

    // Free-running; loads never disturb the blink cadence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            ph_q <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt  <= '0;
            ph_q <= ~ph_q;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign phase = ph_q;
`else
    localparam int unused_div = BLINK_DIV;

    assign phase = 1'b0;
`endif

    // zhi[i]: digit i and every digit above it are zero.
    always_comb begin
        logic run;
        logic off;
        run   = 1'b1;
        off   = 1'b0;
        zhi   = '0;
        led_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run    = run & (val_q[4*i +: 4] == 4'h0);
            zhi[i] = run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            off = (blz_q && (i != 0) && zhi[i])
                | (phase && mask_q[i]);
            led_d[8*i +: 8] = off ? LED_OFF
                            : {~dots_q[i], seg[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st     <= IDLE;
            rdy    <= 1'b1;
            have_q <= 1'b0;
            val_q  <= '0;
            dots_q <= '0;
            mask_q <= '0;
            blz_q  <= 1'b0;
            led    <= {DIGITS{LED_OFF}};
        end else begin
            led <= have_q ? led_d : {DIGITS{LED_OFF}};
            unique case (st)
                IDLE: begin
                    if (acc) begin
                        st     <= LATCH;
                        rdy    <= 1'b0;
                        have_q <= 1'b1;
                        val_q  <= bus.value;
                        dots_q <= bus.dots;
                        mask_q <= bus.blink_mask;
                        blz_q  <= bus.blank_lz;
                    end
                end
                LATCH: begin
                    st  <= IDLE;
                    rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/segdisp_ctrl.md
SEGDISP_CTRL -- requirements
Module: segdisp_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6, meaning the number of 7-segment digits driven (range 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port load_valid, input, 1 bit: the producer offers new display data.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept data.
REQ-007 SHALL have port value, input, 4*DIGITS bits: hex nibbles; nibble i drives digit i, and digit 0 is least significant.
REQ-008 SHALL have port dots, input, DIGITS bits: decimal-point request per digit, 1 = lit.
REQ-009 SHALL have port blink_mask, input, DIGITS bits: per-digit blink enable.
REQ-010 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-011 SHALL have port led, output, 8*DIGITS bits: byte i = {dot, g..a} for digit i, all active-low, registered.

Function
REQ-012 SHALL accept data only on a clock edge where load_valid=1 and load_ready=1, capturing value, dots, blink_mask and blank_lz together.
REQ-013 SHALL implement a two-state FSM: IDLE (load_ready=1) goes to LATCH on accept; LATCH (load_ready=0) returns to IDLE unconditionally after one cycle.
REQ-014 SHALL ignore load_valid while in LATCH; a producer holding load_valid high is accepted at most every second cycle.
REQ-015 SHALL update led on the clock edge following the accept edge (one-cycle latency) and hold it until the next accept or blink phase change.
REQ-016 SHALL encode nibbles 0..F with segment patterns (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-017 SHALL drive led bit 8i+7 low when dots[i]=1 and the digit is not blanked.
REQ-018 SHALL, with blank_lz=1, blank (0xFF) every zero digit above the most significant nonzero digit, where digit 0 is never blanked by this rule and a dot on a blanked digit is also suppressed.
REQ-019 SHALL run a free-running counter 0..BLINK_DIV-1 that toggles a blink phase bit on wrap and is not reset by loads.
REQ-020 SHALL drive digit i to 0xFF while blink phase=1 and blink_mask[i]=1.
REQ-021 SHALL apply a phase change to led on the edge after the counter wraps.
REQ-022 SHALL, when an accept and a phase change occur on the same edge, make the next led reflect both the new data and the new phase.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, set led to all 1s (all off), the latched registers to 0, the counter and phase to 0, and the FSM to IDLE.
REQ-024 SHALL make load_ready=1 in the first cycle after reset release, including when reset is asserted during LATCH; any in-flight data is discarded.

Configuration
REQ-025 SHALL implement blink (REQ-019..REQ-022) only when macro SEGDISP_BLINK_EN is defined.
REQ-026 SHALL, without SEGDISP_BLINK_EN, omit the counter and phase logic, ignore blink_mask, and leave BLINK_DIV unused; all other behaviour is unchanged.

Structure
REQ-027 SHALL take from shared package segdisp_pkg: typedef seg7_t (7-bit), typedef led8_t (8-bit), constant LED_OFF=8'hFF, and the 16-entry segment table.
REQ-028 SHALL instantiate sub-module hex_digit_enc (combinational nibble-to-seg7_t) once per digit via generate.

Verification (DIGITS=6, BLINK_DIV=4, SEGDISP_BLINK_EN defined)
REQ-029 SHALL cover reset: hold reset_n=0 for 3 cycles -> led=48'hFFFFFFFFFFFF and load_ready=1 after release.
REQ-030 SHALL cover load: value=24'h12AB9F, dots=0, mask=0, blank_lz=0, valid for 1 cycle -> load_ready=0 the next cycle, and one edge after accept led bytes 5..0 = F9,A4,88,83,90,8E.
REQ-031 SHALL cover blanking: value=24'h0000A0, blank_lz=1, dots=6'b100001 -> bytes 5..2 = FF, byte 1 = 88, byte 0 = 40.
REQ-032 SHALL cover zero value: value=0, blank_lz=1 -> bytes 5..1 = FF, byte 0 = C0.
REQ-033 SHALL cover blink: blink_mask=6'b000001, value=24'h000003 -> byte 0 alternates B0/FF every 4 cycles while the other bytes stay C0.
REQ-034 SHALL cover back-to-back and reset: load_valid held high for 4 cycles with distinct values -> exactly 2 accepts; reset asserted in LATCH -> led all FF and load_ready=1 after release.
